// File: rtl/regbus_cmd_master_if.sv
// Command port, response port and register-bus signals of regbus_cmd_master.
// The master modport is the initiator's view; slave is the environment's view.
interface regbus_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [13:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
    logic        wr_en;
    logic        rd_en;
    logic [13:0] addr;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, read_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_status, busy,
               wr_en, rd_en, addr, write_data
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, read_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status, busy,
               wr_en, rd_en, addr, write_data
    );
endinterface

// File: rtl/regbus_cmd_master.sv
// Register-bus command master: queues WRITE/READ/POLL commands in a small FIFO,
// runs each one as single-cycle bus accesses and returns one response per command.
module regbus_cmd_master #(
    parameter int CMD_DEPTH  = 4,
    parameter int RD_LATENCY = 0,
    parameter int POLL_MAX   = 16,
    parameter int POLL_GAP   = 4
) (
    input  logic                clk,
    input  logic                rst,
    regbus_cmd_master_if.master bus
);
    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    localparam int LAT_W = $clog2(RD_LATENCY + 2);
    localparam int GAP_W = $clog2(POLL_GAP + 2);

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_READ    = 2'b01;
    localparam logic [1:0] OP_POLL    = 2'b10;
    localparam logic [1:0] RS_OK      = 2'b00;
    localparam logic [1:0] RS_TIMEOUT = 2'b01;
    localparam logic [1:0] RS_ILLEGAL = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_GAP, S_RESP} state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [13:0] addr;
        logic [15:0] data;
        logic [15:0] mask;
    } cmd_t;

    // Masked compare used to decide whether a POLL read has reached its target.
    function automatic logic poll_match(input logic [15:0] sample,
                                        input logic [15:0] exp_val,
                                        input logic [15:0] mask);
        return (sample & mask) == (exp_val & mask);
    endfunction

    cmd_t             fifo_mem_r [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             empty_s, full_s, push_s, pop_s;
    cmd_t             head_s;

    state_t           state_r;
    logic [1:0]       op_r;
    logic [15:0]      exp_r, mask_r;
    logic [ATT_W-1:0] att_r, att_inc_s;
    logic [LAT_W-1:0] lat_r;
    logic [GAP_W-1:0] gap_r;
    logic [13:0]      addr_r;
    logic [15:0]      write_data_r, rsp_data_r;
    logic             wr_en_r, rd_en_r, rsp_valid_r;
    logic [1:0]       rsp_status_r;

    state_t           eval_state_s;
    logic             eval_valid_s, eval_rd_s;
    logic [1:0]       eval_status_s;

    // FIFO status and the push/pop decisions for this cycle.
    always_comb begin
        empty_s = (count_r == '0);
        full_s  = (count_r == CNT_W'(CMD_DEPTH));
        push_s  = bus.cmd_valid && !full_s;
        pop_s   = (state_r == S_IDLE) && !empty_s;
        head_s  = fifo_mem_r[rd_ptr_r];
    end

    // Command FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= '{op: bus.cmd_op, addr: bus.cmd_addr,
                                          data: bus.cmd_data, mask: bus.cmd_mask};
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Outcome of the read sampled this cycle: finish, retry now, or retry after a gap.
    always_comb begin
        att_inc_s     = att_r + ATT_W'(1);
        eval_state_s  = S_RESP;
        eval_valid_s  = 1'b1;
        eval_status_s = RS_OK;
        eval_rd_s     = 1'b0;
        if (op_r != OP_POLL || poll_match(bus.read_data, exp_r, mask_r)) begin
            eval_status_s = RS_OK;
        end else if (att_inc_s == ATT_W'(POLL_MAX)) begin
            eval_status_s = RS_TIMEOUT;
        end else if (POLL_GAP == 0) begin
            eval_state_s = S_READ;
            eval_valid_s = 1'b0;
            eval_rd_s    = 1'b1;
        end else begin
            eval_state_s = S_GAP;
            eval_valid_s = 1'b0;
        end
    end

    // Command sequencer; bus strobes and response fields are set on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            op_r         <= 2'b00;
            exp_r        <= '0;
            mask_r       <= '0;
            att_r        <= '0;
            lat_r        <= '0;
            gap_r        <= '0;
            addr_r       <= '0;
            write_data_r <= '0;
            wr_en_r      <= 1'b0;
            rd_en_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= '0;
            rsp_status_r <= 2'b00;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        op_r   <= head_s.op;
                        exp_r  <= head_s.data;
                        mask_r <= head_s.mask;
                        addr_r <= head_s.addr;
                        att_r  <= '0;
                        lat_r  <= '0;
                        gap_r  <= '0;
                        case (head_s.op)
                            OP_WRITE: begin
                                write_data_r <= head_s.data;
                                wr_en_r      <= 1'b1;
                                state_r      <= S_WRITE;
                            end
                            OP_READ, OP_POLL: begin
                                rd_en_r <= 1'b1;
                                state_r <= S_READ;
                            end
                            default: begin
                                rsp_valid_r  <= 1'b1;
                                rsp_data_r   <= '0;
                                rsp_status_r <= RS_ILLEGAL;
                                state_r      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    wr_en_r      <= 1'b0;
                    rsp_valid_r  <= 1'b1;
                    rsp_data_r   <= exp_r;
                    rsp_status_r <= RS_OK;
                    state_r      <= S_RESP;
                end
                S_READ: begin
                    rd_en_r <= 1'b0;
                    lat_r   <= '0;
                    if (RD_LATENCY == 0) begin
                        rsp_data_r   <= bus.read_data;
                        att_r        <= att_inc_s;
                        rsp_valid_r  <= eval_valid_s;
                        rsp_status_r <= eval_status_s;
                        rd_en_r      <= eval_rd_s;
                        state_r      <= eval_state_s;
                    end else begin
                        state_r <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (lat_r == LAT_W'(RD_LATENCY - 1)) begin
                        rsp_data_r   <= bus.read_data;
                        att_r        <= att_inc_s;
                        rsp_valid_r  <= eval_valid_s;
                        rsp_status_r <= eval_status_s;
                        rd_en_r      <= eval_rd_s;
                        state_r      <= eval_state_s;
                    end else begin
                        lat_r <= lat_r + LAT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_r == GAP_W'(POLL_GAP - 1)) begin
                        gap_r   <= '0;
                        rd_en_r <= 1'b1;
                        state_r <= S_READ;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    wr_en_r     <= 1'b0;
                    rd_en_r     <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    // cmd_ready and busy derive only from registered state, so they react to rst at once.
    assign bus.cmd_ready  = !full_s;
    assign bus.busy       = !empty_s || (state_r != S_IDLE);
    assign bus.wr_en      = wr_en_r;
    assign bus.rd_en      = rd_en_r;
    assign bus.addr       = addr_r;
    assign bus.write_data = write_data_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_status = rsp_status_r;
endmodule

// File: tb/tb_regbus_cmd_master.sv
// Testbench for regbus_cmd_master: one instance with same-cycle read data,
// one with two cycles of read latency; responses checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_regbus_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regbus_cmd_master_if bus0();
    regbus_cmd_master_if bus2();

    regbus_cmd_master #(.CMD_DEPTH(4), .RD_LATENCY(0), .POLL_MAX(16), .POLL_GAP(4))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
    regbus_cmd_master #(.CMD_DEPTH(4), .RD_LATENCY(2), .POLL_MAX(16), .POLL_GAP(4))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

    int total = 0;
    int bad   = 0;
    logic [17:0] exp_q0[$];
    logic [17:0] exp_q2[$];

    // Strobe counters and read timestamps collected from both buses.
    int unsigned cyc = 0, rd_cnt0 = 0, wr_cnt0 = 0, both0 = 0, rd_cnt2 = 0;
    int unsigned rd_time0 [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus0.rd_en === 1'b1) begin
            rd_time0[rd_cnt0 % 64] <= cyc;
            rd_cnt0 <= rd_cnt0 + 1;
        end
        if (bus0.wr_en === 1'b1) wr_cnt0 <= wr_cnt0 + 1;
        if (bus0.wr_en === 1'b1 && bus0.rd_en === 1'b1) both0 <= both0 + 1;
        if (bus2.rd_en === 1'b1) rd_cnt2 <= rd_cnt2 + 1;
    end

    // Register-file stand-in: fixed value, match on 3rd read, or read index.
    int unsigned rd_base = 0;
    int          rd_mode = 0;
    logic [15:0] rd_value = 16'h0000;
    always_comb begin
        case (rd_mode)
            1:       bus0.read_data = ((rd_cnt0 - rd_base) >= 2) ? 16'h1210 : 16'h0000;
            2:       bus0.read_data = 16'(rd_cnt0 - rd_base);
            default: bus0.read_data = rd_value;
        endcase
    end
    assign bus2.read_data = 16'h00A5;

    task automatic drive_cmd0(input logic [1:0] op, input logic [13:0] a,
                              input logic [15:0] d, input logic [15:0] m);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_op    = op;
        bus0.cmd_addr  = a;
        bus0.cmd_data  = d;
        bus0.cmd_mask  = m;
    endtask

    task automatic wait_rsp0(input int budget, output int waited);
        waited = 0;
        while (bus0.rsp_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        bus0.cmd_valid = 1'b0; bus0.cmd_op = 2'b00; bus0.cmd_addr = 14'h0;
        bus0.cmd_data = 16'h0; bus0.cmd_mask = 16'h0; bus0.rsp_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.cmd_op = 2'b00; bus2.cmd_addr = 14'h0;
        bus2.cmd_data = 16'h0; bus2.cmd_mask = 16'h0; bus2.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus0.cmd_ready, bus2.cmd_ready} !== 2'b11) begin
            bad++; $display("FAIL reset_cmd_ready got=%b exp=11", {bus0.cmd_ready, bus2.cmd_ready});
        end
        total++;
        if ({bus0.rsp_valid, bus0.busy, bus0.wr_en, bus0.rd_en, bus0.addr, bus0.write_data,
             bus0.rsp_data, bus0.rsp_status} !== 52'h0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {bus0.rsp_valid, bus0.busy,
                bus0.wr_en, bus0.rd_en, bus0.addr, bus0.write_data, bus0.rsp_data, bus0.rsp_status});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [17:0] exp;
        int unsigned wr0 = wr_cnt0;
        bus0.rsp_ready = 1'b1;
        drive_cmd0(2'b00, 14'h301, 16'h0040, 16'h0000);
        exp_q0.push_back({2'b00, 16'h0040});
        total++;
        if (bus0.cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", bus0.cmd_ready); end
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        total++;
        if (bus0.wr_en !== 1'b0) begin bad++; $display("FAIL wr_early got=%b exp=0", bus0.wr_en); end
        @(negedge clk);
        total++;
        if ({bus0.wr_en, bus0.rd_en, bus0.addr, bus0.write_data} !== {1'b1, 1'b0, 14'h301, 16'h0040}) begin
            bad++; $display("FAIL wr_strobe got=%b/%b/%h/%h exp=1/0/301/0040",
                            bus0.wr_en, bus0.rd_en, bus0.addr, bus0.write_data);
        end
        @(negedge clk);
        total++;
        if (bus0.rsp_valid !== 1'b1) begin
            bad++; $display("FAIL wr_rsp_latency got=%b exp=1", bus0.rsp_valid);
            exp_q0.delete();
        end else begin
            exp = exp_q0.pop_front();
            total++;
            if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                bad++; $display("FAIL wr_rsp got=%h exp=%h", {bus0.rsp_status, bus0.rsp_data}, exp);
            end
        end
        @(negedge clk);
        total++;
        if ({bus0.rsp_valid, bus0.busy, 32'(wr_cnt0 - wr0)} !== {1'b0, 1'b0, 32'd1}) begin
            bad++; $display("FAIL wr_done got=%b/%b/%0d exp=0/0/1", bus0.rsp_valid, bus0.busy, wr_cnt0 - wr0);
        end
    endtask

    task automatic test_read_lat0();
        logic [17:0] exp;
        int w;
        int unsigned rd0 = rd_cnt0;
        rd_mode = 0; rd_value = 16'h00A5;
        drive_cmd0(2'b01, 14'h305, 16'h9999, 16'h0000);
        exp_q0.push_back({2'b00, 16'h00A5});
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        wait_rsp0(20, w);
        total++;
        if (w + 1 !== 3) begin bad++; $display("FAIL rd0_latency got=%0d exp=3", w + 1); end
        if (bus0.rsp_valid === 1'b1) begin
            exp = exp_q0.pop_front();
            total++;
            if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                bad++; $display("FAIL rd0_rsp got=%h exp=%h", {bus0.rsp_status, bus0.rsp_data}, exp);
            end
        end else exp_q0.delete();
        total++;
        if ({32'(rd_cnt0 - rd0), bus0.addr, bus0.write_data} !== {32'd1, 14'h305, 16'h0040}) begin
            bad++; $display("FAIL rd0_bus got=%0d/%h/%h exp=1/305/0040", rd_cnt0 - rd0, bus0.addr, bus0.write_data);
        end
        @(negedge clk);
    endtask

    task automatic test_read_lat2();
        logic [17:0] exp;
        int w = 0;
        int unsigned rd0 = rd_cnt2;
        bus2.rsp_ready = 1'b1;
        bus2.cmd_valid = 1'b1; bus2.cmd_op = 2'b01; bus2.cmd_addr = 14'h305;
        exp_q2.push_back({2'b00, 16'h00A5});
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        while (bus2.rsp_valid !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        total++;
        if (w + 1 !== 5) begin bad++; $display("FAIL rd2_latency got=%0d exp=5", w + 1); end
        if (bus2.rsp_valid === 1'b1) begin
            exp = exp_q2.pop_front();
            total++;
            if ({bus2.rsp_status, bus2.rsp_data} !== exp) begin
                bad++; $display("FAIL rd2_rsp got=%h exp=%h", {bus2.rsp_status, bus2.rsp_data}, exp);
            end
        end else exp_q2.delete();
        total++;
        if (rd_cnt2 - rd0 !== 1) begin bad++; $display("FAIL rd2_strobes got=%0d exp=1", rd_cnt2 - rd0); end
        @(negedge clk);
    endtask

    task automatic test_poll_match();
        logic [17:0] exp;
        int w;
        int unsigned b = rd_cnt0;
        rd_base = rd_cnt0; rd_mode = 1;
        drive_cmd0(2'b10, 14'h30a, 16'h0010, 16'h00FF);
        exp_q0.push_back({2'b00, 16'h1210});
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        wait_rsp0(100, w);
        total++;
        if (w + 1 !== 13) begin bad++; $display("FAIL poll_latency got=%0d exp=13", w + 1); end
        if (bus0.rsp_valid === 1'b1) begin
            exp = exp_q0.pop_front();
            total++;
            if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                bad++; $display("FAIL poll_rsp got=%h exp=%h", {bus0.rsp_status, bus0.rsp_data}, exp);
            end
        end else exp_q0.delete();
        total++;
        if (rd_cnt0 - b !== 3) begin bad++; $display("FAIL poll_reads got=%0d exp=3", rd_cnt0 - b); end
        total++;
        if ({32'(rd_time0[(b + 1) % 64] - rd_time0[b % 64]), 32'(rd_time0[(b + 2) % 64] - rd_time0[(b + 1) % 64])}
            !== {32'd5, 32'd5}) begin
            bad++; $display("FAIL poll_spacing got=%0d,%0d exp=5,5", rd_time0[(b + 1) % 64] - rd_time0[b % 64],
                            rd_time0[(b + 2) % 64] - rd_time0[(b + 1) % 64]);
        end
        @(negedge clk);
    endtask

    task automatic test_poll_timeout();
        logic [17:0] exp;
        int w;
        int unsigned b = rd_cnt0;
        int unsigned both_start = both0;
        rd_base = rd_cnt0; rd_mode = 2;
        drive_cmd0(2'b10, 14'h30b, 16'hFFFF, 16'hFFFF);
        exp_q0.push_back({2'b01, 16'h000F});
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        wait_rsp0(200, w);
        total++;
        if (bus0.rsp_valid !== 1'b1) begin
            bad++; $display("FAIL timeout_rsp_wait got=no_rsp exp=rsp within 200 cycles");
            exp_q0.delete();
        end else begin
            exp = exp_q0.pop_front();
            total++;
            if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                bad++; $display("FAIL timeout_rsp got=%h exp=%h", {bus0.rsp_status, bus0.rsp_data}, exp);
            end
        end
        total++;
        if ({32'(rd_cnt0 - b), 32'(both0 - both_start)} !== {32'd16, 32'd0}) begin
            bad++; $display("FAIL timeout_reads got=%0d/%0d exp=16/0", rd_cnt0 - b, both0 - both_start);
        end
        @(negedge clk);
        rd_mode = 0;
    endtask

    task automatic test_illegal();
        logic [17:0] exp;
        int w;
        int unsigned r0 = rd_cnt0, wr0 = wr_cnt0;
        drive_cmd0(2'b11, 14'h123, 16'hBEEF, 16'hFFFF);
        exp_q0.push_back({2'b10, 16'h0000});
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        wait_rsp0(20, w);
        total++;
        if (w + 1 !== 2) begin bad++; $display("FAIL illegal_latency got=%0d exp=2", w + 1); end
        if (bus0.rsp_valid === 1'b1) begin
            exp = exp_q0.pop_front();
            total++;
            if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                bad++; $display("FAIL illegal_rsp got=%h exp=%h", {bus0.rsp_status, bus0.rsp_data}, exp);
            end
        end else exp_q0.delete();
        total++;
        if ({32'(rd_cnt0 - r0), 32'(wr_cnt0 - wr0)} !== {32'd0, 32'd0}) begin
            bad++; $display("FAIL illegal_strobes got=%0d/%0d exp=0/0", rd_cnt0 - r0, wr_cnt0 - wr0);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [15:0] dat [5] = '{16'h1111, 16'h0000, 16'h3333, 16'h0111, 16'h0000};
        logic [17:0] rsp [5] = '{{2'b00, 16'h1111}, {2'b00, 16'h0111}, {2'b00, 16'h3333},
                                 {2'b00, 16'h0111}, {2'b10, 16'h0000}};
        logic [17:0] exp;
        logic accepted;
        logic refused = 1'b1;
        int acc = 0, guard = 0, w;
        int unsigned wr0 = wr_cnt0;
        rd_mode = 0; rd_value = 16'h0111;
        bus0.rsp_ready = 1'b0;
        while (acc < 5 && guard < 50) begin
            drive_cmd0(ops[acc], 14'(14'h310 + acc), dat[acc], 16'hFFFF);
            accepted = bus0.cmd_ready;
            @(negedge clk);
            guard++;
            if (accepted === 1'b1) begin
                exp_q0.push_back(rsp[acc]);
                acc++;
            end
        end
        total++;
        if ({32'(acc), 32'(guard)} !== {32'd5, 32'd5}) begin
            bad++; $display("FAIL b2b_accept got=%0d in %0d cycles exp=5 in 5", acc, guard);
        end
        drive_cmd0(2'b00, 14'h314, 16'h6666, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            if (bus0.cmd_ready !== 1'b0) refused = 1'b0;
            @(negedge clk);
        end
        bus0.cmd_valid = 1'b0;
        total++;
        if ({refused, bus0.busy} !== 2'b11) begin
            bad++; $display("FAIL b2b_full got=%b/%b exp=1/1", refused, bus0.busy);
        end
        bus0.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp0(40, w);
            total++;
            if (bus0.rsp_valid !== 1'b1) begin
                bad++; $display("FAIL b2b_rsp%0d_wait got=no_rsp exp=rsp", i);
            end else if (exp_q0.size() == 0) begin
                bad++; $display("FAIL b2b_rsp%0d_extra got=%h exp=none", i, {bus0.rsp_status, bus0.rsp_data});
            end else begin
                exp = exp_q0.pop_front();
                if ({bus0.rsp_status, bus0.rsp_data} !== exp) begin
                    bad++; $display("FAIL b2b_rsp%0d got=%h exp=%h", i, {bus0.rsp_status, bus0.rsp_data}, exp);
                end
            end
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        total++;
        if ({bus0.busy, bus0.rsp_valid, 32'(wr_cnt0 - wr0)} !== {1'b0, 1'b0, 32'd2}) begin
            bad++; $display("FAIL b2b_drain got=%b/%b/%0d exp=0/0/2", bus0.busy, bus0.rsp_valid, wr_cnt0 - wr0);
        end
        exp_q0.delete();
    endtask

    task automatic test_reset_rdwait();
        bus2.rsp_ready = 1'b1;
        bus2.cmd_valid = 1'b1; bus2.cmd_op = 2'b01; bus2.cmd_addr = 14'h306;
        @(negedge clk);
        bus2.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus2.busy, bus2.rd_en, bus2.rsp_valid} !== 3'b100) begin
            bad++; $display("FAIL rdwait_state got=%b exp=100", {bus2.busy, bus2.rd_en, bus2.rsp_valid});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus2.rd_en, bus2.rsp_valid, bus2.busy, bus2.cmd_ready} !== 4'b0001) begin
            bad++; $display("FAIL rdwait_reset got=%b exp=0001",
                            {bus2.rd_en, bus2.rsp_valid, bus2.busy, bus2.cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({bus2.rsp_valid, bus2.busy} !== 2'b00) begin
            bad++; $display("FAIL rdwait_lost got=%b exp=00", {bus2.rsp_valid, bus2.busy});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_lat0();
        test_read_lat2();
        test_poll_match();
        test_poll_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_rdwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
